// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame width and line levels.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } uart_state_e;

  function automatic logic uart_state_busy(input uart_state_e s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side byte handshake of the UART transmitter (valid/ready plus data).
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);

  logic                 tx_valid;
  logic [DATA_BITS-1:0] TX_DATA;
  logic                 tx_ready;

  modport master (
    output tx_valid,
    output TX_DATA,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  TX_DATA,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx_shift.sv
// Load/shift-left register for the UART transmitter; exposes the current and next MSB.
module uart_tx_shift
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 msb_o,
  output logic                 next_msb_o
);

  logic [DATA_BITS-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = {sr_q[DATA_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_o      = sr_q[DATA_BITS-1];
  assign next_msb_o = sr_q[DATA_BITS-2];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, DATA_BITS data bits MSB-first, stop bit(s), one bit per tx_tick.
// Define UART_TX_TWO_STOP_EN for a two-tick stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int CNT_W     = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     tx_en,
  input  logic     tx_tick,
  uart_tx_if.slave bus,
  output logic     tx_out,
  output logic     tx_busy,
  output logic     tx_done
);

  if (DATA_BITS < 5 || DATA_BITS > 8 || (2 ** CNT_W) <= DATA_BITS) begin : g_param_check
    $error("uart_tx: DATA_BITS must be 5..8 and 2**CNT_W must exceed DATA_BITS");
  end

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tx_out_q, tx_out_d;
  logic             done_q, done_d;
`ifdef UART_TX_TWO_STOP_EN
  logic             stop_q, stop_d;
`endif

  logic handshake;
  logic sr_load;
  logic sr_shift;
  logic sr_msb;
  logic sr_next_msb;

  assign bus.tx_ready = (state_q == IDLE) & tx_en;
  assign handshake    = bus.tx_valid & bus.tx_ready;

  uart_tx_shift #(
    .DATA_BITS (DATA_BITS)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .load_i     (sr_load),
    .shift_i    (sr_shift),
    .data_i     (bus.TX_DATA),
    .msb_o      (sr_msb),
    .next_msb_o (sr_next_msb)
  );

  // A tick arriving with the handshake is ignored: SYNC waits for the next
  // tick so the start bit spans a full bit period.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    tx_out_d = tx_out_q;
    done_d   = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    stop_d   = stop_q;
`endif
    case (state_q)
      IDLE: begin
        tx_out_d = LINE_IDLE;
        if (handshake) begin
          sr_load = 1'b1;
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (tx_tick) begin
          state_d  = START;
          tx_out_d = LINE_START;
        end
      end
      START: begin
        if (tx_tick) begin
          state_d  = DATA;
          tx_out_d = sr_msb;
          count_d  = CNT_W'(DATA_BITS - 1);
        end
      end
      DATA: begin
        if (tx_tick) begin
          if (count_q != '0) begin
            sr_shift = 1'b1;
            tx_out_d = sr_next_msb;
            count_d  = count_q - CNT_W'(1);
          end else begin
            state_d  = STOP;
            tx_out_d = LINE_IDLE;
          end
        end
      end
      STOP: begin
`ifdef UART_TX_TWO_STOP_EN
        if (tx_tick) begin
          if (!stop_q) begin
            stop_d = 1'b1;
          end else begin
            stop_d  = 1'b0;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
`else
        if (tx_tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`endif
      end
      default: begin
        state_d  = IDLE;
        tx_out_d = LINE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      tx_out_q <= LINE_IDLE;
      done_q   <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      tx_out_q <= tx_out_d;
      done_q   <= done_d;
`ifdef UART_TX_TWO_STOP_EN
      stop_q   <= stop_d;
`endif
    end
  end

  assign tx_out  = tx_out_q;
  assign tx_busy = uart_state_busy(state_q);
  assign tx_done = done_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter; the counterpart of the team's UART receiver. Shares its baud tick and frame format: 1 start bit (0), DATA_BITS data bits MSB-first, 1 stop bit (1), no parity.
- Accepts parallel bytes over a valid/ready handshake and shifts them out one bit per baud tick.
- Sits between the host-side byte source and the uart_baud_gen tick output; its tx_out drives the line the receiver samples.

Parameters:
- DATA_BITS, 8, data bits per frame (legal range 5..8; receiver pairing requires 8).
- CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > DATA_BITS.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- tx_en  in  1  transmitter enable; gates acceptance of new bytes only.
- tx_tick  in  1  one-clk baud strobe, one per bit period.
- tx_valid  in  1  host presents a byte on TX_DATA.
- TX_DATA  in  DATA_BITS  byte to send; sampled only on handshake.
- tx_ready  out  1  transmitter can accept a byte this cycle.
- tx_out  out  1  serial line, registered, idle high.
- tx_busy  out  1  frame in progress.
- tx_done  out  1  one-clk pulse when the stop bit completes.

Behaviour:
- Reset (rst=0, async): state=IDLE, tx_out=1, tx_busy=0, tx_done=0, shift register=0, count=0. Asserting reset mid-frame returns the line high immediately and drops the frame.
- tx_ready = (state==IDLE) & tx_en (combinational). A handshake occurs when tx_valid & tx_ready at a rising clk edge; TX_DATA is latched into the shift register.
- States: IDLE, SYNC, START, DATA, STOP.
  - IDLE: tx_out=1. On handshake go to SYNC.
  - SYNC: tx_out=1; waits for the first tx_tick so the start bit is a full period. On tick go to START, tx_out<=0.
  - START: on tick go to DATA; tx_out<=shift[DATA_BITS-1]; count<=DATA_BITS-1.
  - DATA: on each tick, if count!=0, shift left, tx_out<=next MSB, count--. If count==0, go to STOP with tx_out<=1.
  - STOP: on tick go to IDLE; pulse tx_done for that one cycle.
- tx_busy=1 in SYNC, START, DATA and STOP.
- Bit order is MSB first, matching the receiver, which fills bit DATA_BITS-1 first.
- Each line level lasts exactly one tick interval; the START, DATA and STOP states advance only on tx_tick.
- Frame length is DATA_BITS+2 tick intervals after SYNC.
- tx_tick in the same cycle as the handshake: the handshake moves to SYNC; that tick is not consumed.
- tx_en dropped mid-frame: the current frame completes; no new handshake occurs until tx_en returns high.
- tx_valid held across frames: back-to-back bytes are accepted in the IDLE cycle after STOP. There is a minimum of 1 idle clk plus the SYNC wait between frames.
- TX_DATA changes after the handshake have no effect.

Optional Feature:
- Macro UART_TX_TWO_STOP_EN.
- Defined: STOP lasts two tick intervals, tracked by an internal 1-bit stop counter; tx_done pulses after the second interval.
- Undefined: single stop bit as above.
- Both settings are compatible with the receiver, which returns to idle on the first high stop sample.

Decomposition:
- Package uart_pkg holds:
  - the state encoding constants (IDLE=0, SYNC=1, START=2, DATA=3, STOP=4), 3 bits wide;
  - UART_DATA_BITS=8;
  - line level constants LINE_IDLE=1, LINE_START=0.
- The receiver and transmitter share the package.
- No sub-module is required. An optional uart_tx_shift (load/shift register with MSB output) is the natural split if reused.

Test Plan:
- Reset then idle: rst=0 for 3 clk, release → tx_out=1, tx_ready=1 (tx_en=1), tx_busy=0; no change for 20 ticks without tx_valid.
- Single byte 8'hA5 with tick every 16 clk → line sequence per tick 0,1,0,1,0,0,1,0,1,1. tx_done pulses once, 10 ticks after SYNC exit. Loopback into the receiver gives RX_DATA=8'hA5 and rx_valid high.
- Back-to-back 8'h00 then 8'hFF with tx_valid held → two complete frames, tx_ready low throughout each, second start bit after the first stop bit plus the SYNC wait.
- Handshake coincident with tx_tick → tx_out stays 1 for one full tick interval before the start bit; start bit lasts exactly 16 clk.
- tx_en dropped during DATA bit 3 of 8'h3C → frame finishes correctly, then tx_ready=0 and a pending tx_valid is ignored until tx_en=1.
- rst asserted during DATA → tx_out=1 asynchronously, tx_busy=0. After release, a new byte 8'h81 transmits cleanly. With UART_TX_TWO_STOP_EN defined, the stop high lasts 2 ticks before tx_done.
